// File: rtl/axi4_stream_pkt_gen_pkg.sv
// Shared types and helpers for the command-driven AXI4-Stream packet generator.
// Holds the FSM state encoding plus tkeep and word-count arithmetic.
package axi4_stream_pkt_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam int unsigned MAX_B = 128;

    // Ones in the low L lanes, where L = bytes mod b and L = 0 means a full word.
    function automatic logic [MAX_B-1:0] keep_mask(
        input int unsigned bytes,
        input int unsigned b
    );
        int unsigned l;
        l = bytes % b;
        if (l == 0) begin
            l = b;
        end
        keep_mask = '0;
        for (int unsigned i = 0; i < MAX_B; i++) begin
            keep_mask[i] = (i < l);
        end
    endfunction

    // Wide enough that bytes = 2^PKT_SIZE_WIDTH-1 cannot overflow the rounding add.
    function automatic int unsigned word_count(
        input int unsigned bytes,
        input int unsigned b
    );
        return (bytes + b - 1) / b;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
// Width parameters must match the instance that drives it.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    localparam int B = TDATA_WIDTH / 8;

    logic [TDATA_WIDTH-1:0] tdata;
    logic [B-1:0]           tstrb;
    logic [B-1:0]           tkeep;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TID_WIDTH-1:0]   tid;
    logic                   tvalid;
    logic                   tready;

    modport master (
        output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
        output tready
    );

endinterface

// File: rtl/axi4_stream_pkt_gen.sv
// Command-driven AXI4-Stream packet source: one packet per command with a
// counting byte pattern, partial tkeep on the last word and an idle gap after.
module axi4_stream_pkt_gen
    import axi4_stream_pkt_gen_pkg::*;
#(
    parameter int TDATA_WIDTH    = 32,
    parameter int TUSER_WIDTH    = 1,
    parameter int TDEST_WIDTH    = 1,
    parameter int TID_WIDTH      = 1,
    parameter int PKT_SIZE_WIDTH = 16,
    parameter int GAP_WIDTH      = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [PKT_SIZE_WIDTH-1:0] cmd_size_i,
    input  logic [GAP_WIDTH-1:0]      cmd_gap_i,
    input  logic [TDEST_WIDTH-1:0]    cmd_tdest_i,
    input  logic [TID_WIDTH-1:0]      cmd_tid_i,
    output logic                      busy_o,
    output logic                      zero_size_o,
    output logic [31:0]               pkts_sent_o,
    axi4_stream_if.master             pkt_o
);

    localparam int unsigned B   = TDATA_WIDTH / 8;
    localparam int          WCW = PKT_SIZE_WIDTH + 1;

    state_t state_q, state_d;

    logic [WCW-1:0]         words_left_q;
    logic [7:0]             byte_base_q;
    logic [B-1:0]           last_keep_q;
    logic [GAP_WIDTH-1:0]   gap_q;
    logic [GAP_WIDTH-1:0]   gap_cnt_q;
    logic [TDEST_WIDTH-1:0] tdest_q;
    logic [TID_WIDTH-1:0]   tid_q;
    logic                   first_q;
    logic [31:0]            pkts_q;
    logic                   zero_q;

    logic cmd_fire;
    logic accept;
    logic send;
    logic is_last;
    logic hs;

    assign cmd_fire = cmd_valid_i && cmd_ready_o;
    assign accept   = cmd_fire && (cmd_size_i != '0);
    assign send     = (state_q == ST_SEND);
    assign is_last  = (words_left_q == WCW'(1));
    assign hs       = send && pkt_o.tready;

    assign pkts_sent_o = pkts_q;
    assign zero_size_o = zero_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (accept) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                busy_o = 1'b1;
                if (hs && is_last) begin
                    state_d = (gap_q != '0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                busy_o = 1'b1;
                if (gap_cnt_q == GAP_WIDTH'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The whole command is captured here; inputs are ignored until the next IDLE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            words_left_q <= '0;
            byte_base_q  <= '0;
            last_keep_q  <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            tdest_q      <= '0;
            tid_q        <= '0;
            first_q      <= 1'b0;
            pkts_q       <= '0;
            zero_q       <= 1'b0;
        end else begin
            zero_q <= cmd_fire && (cmd_size_i == '0);
            if (accept) begin
                words_left_q <= WCW'(word_count(32'(cmd_size_i), B));
                last_keep_q  <= B'(keep_mask(32'(cmd_size_i), B));
                byte_base_q  <= pkts_q[7:0];
                gap_q        <= cmd_gap_i;
                tdest_q      <= cmd_tdest_i;
                tid_q        <= cmd_tid_i;
                first_q      <= 1'b1;
            end else if (hs) begin
                words_left_q <= words_left_q - WCW'(1);
                byte_base_q  <= byte_base_q + 8'(B);
                first_q      <= 1'b0;
                if (is_last) begin
                    pkts_q    <= pkts_q + 32'd1;
                    gap_cnt_q <= gap_q;
                end
            end else if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
            end
        end
    end

    logic [B-1:0]           keep;
    logic [TDATA_WIDTH-1:0] data;
    logic [TUSER_WIDTH-1:0] user;

    always_comb begin
        keep = is_last ? last_keep_q : '1;
        data = '0;
        for (int i = 0; i < int'(B); i++) begin
            data[8*i +: 8] = keep[i] ? (byte_base_q + 8'(i)) : 8'h00;
        end
        user    = '0;
        user[0] = first_q;
    end

    // Fields are forced to zero whenever no word is being offered.
    always_comb begin
        pkt_o.tvalid = send;
        pkt_o.tdata  = send ? data : '0;
        pkt_o.tkeep  = send ? keep : '0;
        pkt_o.tstrb  = send ? keep : '0;
        pkt_o.tlast  = send && is_last;
        pkt_o.tuser  = send ? user : '0;
        pkt_o.tdest  = send ? tdest_q : '0;
        pkt_o.tid    = send ? tid_q : '0;
    end

endmodule

// File: tb/tb_axi4_stream_pkt_gen.sv
// Randomized bench for axi4_stream_pkt_gen against a byte-level packet model.
// Directed cases cover latency, back-pressure, gaps, size 0 and mid-packet reset.
module tb_axi4_stream_pkt_gen;

    localparam int B = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_size = '0;
    logic [7:0]  cmd_gap = '0;
    logic [0:0]  cmd_tdest = '0;
    logic [0:0]  cmd_tid = '0;
    logic        busy;
    logic        zero_size;
    logic [31:0] pkts_sent;

    always #5 clk = ~clk;

    axi4_stream_if #(
        .TDATA_WIDTH(32),
        .TUSER_WIDTH(1),
        .TDEST_WIDTH(1),
        .TID_WIDTH(1)
    ) pkt_if ();

    axi4_stream_pkt_gen #(
        .TDATA_WIDTH(32),
        .TUSER_WIDTH(1),
        .TDEST_WIDTH(1),
        .TID_WIDTH(1),
        .PKT_SIZE_WIDTH(16),
        .GAP_WIDTH(8)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_size_i(cmd_size),
        .cmd_gap_i(cmd_gap),
        .cmd_tdest_i(cmd_tdest),
        .cmd_tid_i(cmd_tid),
        .busy_o(busy),
        .zero_size_o(zero_size),
        .pkts_sent_o(pkts_sent),
        .pkt_o(pkt_if)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic        dest;
        logic        id;
        int          gap;
    } word_t;

    word_t exp_q[$];
    word_t mw;

    int n_cmp = 0;
    int n_err = 0;
    int model_pkts = 0;
    int gap_left = -1;
    int hs_cnt = 0;
    int rmode = 0;
    int pat_i = 0;
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic        stalled = 1'b0;
    logic [43:0] snap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [43:0] bundle();
        return {pkt_if.tdata, pkt_if.tkeep, pkt_if.tstrb, pkt_if.tlast,
                pkt_if.tuser, pkt_if.tdest, pkt_if.tid};
    endfunction

    // Packet model: byte n = (P + n) mod 256, packed little-endian B bytes per word.
    task automatic push_pkt(input int size, input int gap, input logic dest, input logic id);
        int p;
        int nw;
        p  = model_pkts % 256;
        nw = (size + B - 1) / B;
        for (int w = 0; w < nw; w++) begin
            word_t x;
            x.data = '0;
            x.keep = '0;
            for (int j = 0; j < B; j++) begin
                int n;
                n = w * B + j;
                if (n < size) begin
                    x.data[8*j +: 8] = 8'((p + n) % 256);
                    x.keep[j] = 1'b1;
                end
            end
            x.last = (w == nw - 1);
            x.user = (w == 0);
            x.dest = dest;
            x.id   = id;
            x.gap  = gap;
            exp_q.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            gap_left   = -1;
            stalled    = 1'b0;
            model_pkts = 0;
            hs_cnt     = 0;
            pkt_if.tready = 1'b1;
        end else begin
            if (rmode == 0) begin
                pkt_if.tready = 1'b1;
            end else if (rmode == 1) begin
                pkt_if.tready = 1'($urandom_range(0, 1));
            end else begin
                pkt_if.tready = pat[pat_i % 6];
                pat_i++;
            end
            if (stalled) begin
                check("hold_valid", pkt_if.tvalid, 1);
                check("hold_fields", bundle(), snap);
            end
            if (gap_left > 0) begin
                check("gap_tvalid", pkt_if.tvalid, 0);
                check("gap_busy", busy, 1);
                check("gap_rdy", cmd_ready, 0);
                gap_left--;
            end else if (gap_left == 0) begin
                check("post_rdy", cmd_ready, 1);
                gap_left = -1;
            end
            stalled = pkt_if.tvalid && !pkt_if.tready;
            snap = bundle();
            if (pkt_if.tvalid && pkt_if.tready) begin
                check("q_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mw = exp_q.pop_front();
                    check("tdata", pkt_if.tdata, mw.data);
                    check("tkeep", pkt_if.tkeep, mw.keep);
                    check("tstrb", pkt_if.tstrb, mw.keep);
                    check("tlast", pkt_if.tlast, mw.last);
                    check("tuser", pkt_if.tuser, mw.user);
                    check("tdest", pkt_if.tdest, mw.dest);
                    check("tid", pkt_if.tid, mw.id);
                    hs_cnt++;
                    if (mw.last) begin
                        model_pkts++;
                        gap_left = mw.gap;
                    end
                end
            end
        end
    end

    task automatic issue(input int size, input int gap, input logic dest, input logic id);
        int t;
        logic [31:0] pre;
        t = 0;
        while (!cmd_ready && t < 70000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", cmd_ready, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_size  = 16'(size);
        cmd_gap   = 8'(gap);
        cmd_tdest = dest;
        cmd_tid   = id;
        pre = pkts_sent;
        if (size != 0) begin
            push_pkt(size, gap, dest, id);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_size  = 16'($urandom);
        cmd_gap   = 8'($urandom);
        cmd_tdest = 1'($urandom);
        cmd_tid   = 1'($urandom);
        if (size != 0) begin
            check("lat_tvalid", pkt_if.tvalid, 1);
        end else begin
            check("zero_pulse", zero_size, 1);
            check("zero_tvalid", pkt_if.tvalid, 0);
            check("zero_rdy", cmd_ready, 1);
            @(negedge clk);
            check("zero_clr", zero_size, 0);
            check("zero_pkts", pkts_sent, pre);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || gap_left >= 0 || !cmd_ready) && t < 70000) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        check("pkts_sent", pkts_sent, model_pkts);
    endtask

    initial begin
        int base;
        int t;
        pkt_if.tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tvalid", pkt_if.tvalid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_zero", zero_size, 0);
        check("rst_pkts", pkts_sent, 0);
        check("rst_fields", bundle(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        rmode = 0;
        issue(10, 0, 1'b0, 1'b0);
        wait_done();

        issue(4, 0, 1'b1, 1'b0);
        issue(5, 0, 1'b0, 1'b1);
        wait_done();

        rmode = 2;
        pat_i = 0;
        issue(10, 0, 1'b0, 1'b0);
        wait_done();

        rmode = 0;
        issue(6, 3, 1'b1, 1'b1);
        wait_done();

        issue(0, 0, 1'b0, 1'b0);

        issue(40, 0, 1'b0, 1'b0);
        base = hs_cnt;
        t = 0;
        while (hs_cnt - base < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mid_words", hs_cnt - base, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", pkt_if.tvalid, 0);
        check("mid_rst_pkts", pkts_sent, 0);
        check("mid_rst_rdy", cmd_ready, 1);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        issue(8, 0, 1'b0, 1'b0);
        wait_done();

        issue(300, 1, 1'b1, 1'b0);
        wait_done();

        for (int k = 0; k < 30; k++) begin
            int sz;
            rmode = $urandom_range(0, 2);
            sz = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 70);
            issue(sz, $urandom_range(0, 4), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                wait_done();
            end
        end
        wait_done();

        rmode = 0;
        issue(65535, 2, 1'b1, 1'b1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
